mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage controller driving the MEMWB latch inputs. Takes the EXMEM outputs, issues the
//  dcache read/write request, holds the pipeline until dhit, and captures load data. Also owns
//  the LL/SC link register, which is cleared by coherence invalidations from the other core.
//  Sits between the EXMEM latch and the MEMWB latch. Its wb_* outputs feed the MEMWB *_i inputs.
// PARAMETERS
//  WORD_W     32         data/address width (matches word_t)
//  LINK_EN    1          0: LL behaves as LW, SC behaves as SW and always returns 1
// PORTS
//  CLK          in   1       clock, rising edge
//  nRST         in   1       asynchronous active-low reset
//  ex_valid     in   1       EXMEM holds a live instruction
//  ex_Mem       in   2       00 none, 01 load (LW/LL), 10 store (SW/SC), 11 treated as 00
//  ex_opcode    in   6       opcode_t; LL/SC are distinguished by opcode
//  ex_alu_out   in   WORD_W  effective address / ALU result
//  ex_store     in   WORD_W  store data
//  ex_RegW      in   1       writeback enable
//  ex_halt      in   1       halt marker
//  flush        in   1       squash the current instruction's writeback
//  dhit         in   1       dcache completed the request this cycle
//  dmemload     in   WORD_W  dcache read data, valid with dhit
//  snoop_inv    in   1       coherence invalidation this cycle
//  snoop_addr   in   WORD_W  invalidated address (word-aligned compare on [WORD_W-1:2])
//  dmemREN      out  1       dcache read request
//  dmemWEN      out  1       dcache write request
//  dmemaddr     out  WORD_W  request address
//  dmemstore    out  WORD_W  request write data
//  mem_stall    out  1       hold PC/IFID/IDEX/EXMEM this cycle
//  wb_valid     out  1       wb_* are meaningful this cycle
//  wb_data      out  WORD_W  load data, SC result (0/1), or ex_alu_out pass-through
//  wb_RegW      out  1       ex_RegW gated by flush and wb_valid
//  wb_halt      out  1       ex_halt pass-through (0 while stalled)
// BEHAVIOUR
//  States: IDLE, ACCESS, DONE. Reset: IDLE. Link valid is 0 and link address is 0.
//   All request and wb outputs are 0 at reset.
//  IDLE, no memory op (ex_Mem 00/11 or !ex_valid):
//   - Combinational pass-through: wb_data=ex_alu_out, wb_valid=ex_valid.
//   - wb_RegW=ex_RegW&ex_valid&!flush. wb_halt=ex_halt&ex_valid.
//   - mem_stall=0.
//  IDLE, memory op accepted:
//   - Latch addr, store data, op kind, RegW and halt. Next state is ACCESS.
//   - mem_stall=1 and wb_valid=0 this cycle.
//  IDLE, SC with link miss (link invalid or address mismatch):
//   - No dcache request.
//   - wb_data=0, wb_valid=1, mem_stall=0.
//   - Link cleared. Stays in IDLE.
//  ACCESS:
//   - dmemREN/dmemWEN driven only from latched registers, held stable until dhit.
//   - mem_stall=1.
//   - On dhit: capture dmemload (loads) or the constant 1 (SC), then go to DONE.
//  DONE (exactly 1 cycle):
//   - wb_valid=1, wb_data=captured value, requests deasserted.
//   - mem_stall=0, so EXMEM advances. Next state is IDLE.
//   - Min latency for a memory op = 2 stall cycles + 1 DONE cycle (dhit in first ACCESS cycle).
//  flush:
//   - Sampled in any state. In ACCESS it sets a sticky squash bit; the in-flight request still
//     completes (never abandoned mid-request).
//   - In DONE, a set squash bit forces wb_RegW=0 and wb_halt=0. Squash clears on leaving DONE.
//  Link register:
//   - LL dhit sets link={1,addr}.
//   - Cleared by any SC completion, by our own SW/SC dhit to the link address,
//     or by snoop_inv with a matching snoop_addr[WORD_W-1:2].
//   - If snoop_inv hits the link while an SC is in ACCESS, the request is already issued; the SC
//     still completes with result 1. The cache coherence protocol guarantees ordering.
//   - Same-cycle LL dhit and matching snoop_inv: the snoop wins and the link ends invalid.
//  Reset mid-ACCESS: asynchronous return to IDLE. Requests drop immediately and the link clears.
// TESTING
//  LW addr 0x100, dhit after 3 ACCESS cycles -> REN high 3 cycles, then DONE with wb_data=dmemload.
//   mem_stall=1 for 4 cycles.
//  ADD result 0x55, no memory op -> same-cycle wb_data=0x55, wb_valid=1, mem_stall=0, no REN/WEN.
//  LL 0x200, then SC 0x200 data 7 -> WEN with dmemstore=7, wb_data=1. A second SC 0x200 -> no WEN,
//   wb_data=0.
//  LL 0x200, then snoop_inv 0x204 (link kept), then snoop_inv 0x200 -> following SC 0x200 fails
//   with wb_data=0 and no WEN.
//  SW in ACCESS with flush pulsed -> WEN held until dhit, DONE has wb_RegW=0, then IDLE.
//  nRST low mid-ACCESS -> dmemREN/WEN=0 asynchronously, state IDLE, and the next SC fails.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns EXMEM contents into dcache requests, stalls the pipe until
// dhit, feeds the MEMWB latch, and keeps the LL/SC link register that coherence snoops clear.
module mem_stage_ctrl #(
    parameter int WORD_W  = 32,
    parameter bit LINK_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    input  logic [1:0]        ex_Mem,
    input  logic [5:0]        ex_opcode,
    input  logic [WORD_W-1:0] ex_alu_out,
    input  logic [WORD_W-1:0] ex_store,
    input  logic              ex_RegW,
    input  logic              ex_halt,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_data,
    output logic              wb_RegW,
    output logic              wb_halt
);

    localparam logic [5:0] OP_LL = 6'b110000;
    localparam logic [5:0] OP_SC = 6'b111000;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q;
    logic [WORD_W-1:0] addr_q, store_q, data_q;
    logic              load_q, ll_q, sc_q, regw_q, halt_q, squash_q;
    logic              link_valid_q, link_valid_d;
    logic [WORD_W-1:0] link_addr_q, link_addr_d;

    logic is_load, is_store, is_ll, is_sc, link_hit, sc_miss, accept;

    assign is_load  = ex_valid && (ex_Mem == 2'b01);
    assign is_store = ex_valid && (ex_Mem == 2'b10);
    assign is_ll    = LINK_EN && is_load && (ex_opcode == OP_LL);
    assign is_sc    = is_store && (ex_opcode == OP_SC);
    assign link_hit = link_valid_q && (link_addr_q[WORD_W-1:2] == ex_alu_out[WORD_W-1:2]);
    // A failing SC resolves in IDLE without touching the cache.
    assign sc_miss  = LINK_EN && is_sc && !link_hit;
    assign accept   = (is_load || is_store) && !sc_miss;

    // Requests come only from latched state so they stay stable across the whole access.
    assign dmemREN   = (state_q == ACCESS) && load_q;
    assign dmemWEN   = (state_q == ACCESS) && !load_q;
    assign dmemaddr  = addr_q;
    assign dmemstore = store_q;

    // Link update order: completion effects first, then a snoop against the resulting address,
    // so a snoop in the same cycle as an LL dhit leaves the link invalid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if ((state_q == IDLE) && sc_miss) begin
            link_valid_d = 1'b0;
        end
        if ((state_q == ACCESS) && dhit) begin
            if (ll_q) begin
                link_valid_d = 1'b1;
                link_addr_d  = addr_q;
            end else if (!load_q && (sc_q || (addr_q[WORD_W-1:2] == link_addr_q[WORD_W-1:2]))) begin
                link_valid_d = 1'b0;
            end
        end
        if (snoop_inv && (snoop_addr[WORD_W-1:2] == link_addr_d[WORD_W-1:2])) begin
            link_valid_d = 1'b0;
        end
    end

    always_comb begin
        mem_stall = 1'b0;
        wb_valid  = 1'b0;
        wb_data   = '0;
        wb_RegW   = 1'b0;
        wb_halt   = 1'b0;
        case (state_q)
            IDLE: begin
                mem_stall = accept;
                wb_valid  = ex_valid && !accept;
                wb_data   = sc_miss ? '0 : ex_alu_out;
                wb_RegW   = ex_valid && ex_RegW && !flush && !accept;
                wb_halt   = ex_valid && ex_halt && !accept;
            end
            ACCESS: begin
                mem_stall = 1'b1;
            end
            DONE: begin
                wb_valid = 1'b1;
                wb_data  = data_q;
                wb_RegW  = regw_q && !squash_q && !flush;
                wb_halt  = halt_q && !squash_q && !flush;
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            store_q      <= '0;
            data_q       <= '0;
            load_q       <= 1'b0;
            ll_q         <= 1'b0;
            sc_q         <= 1'b0;
            regw_q       <= 1'b0;
            halt_q       <= 1'b0;
            squash_q     <= 1'b0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= ex_alu_out;
                        store_q  <= ex_store;
                        load_q   <= is_load;
                        ll_q     <= is_ll;
                        sc_q     <= is_sc;
                        regw_q   <= ex_RegW;
                        halt_q   <= ex_halt;
                        squash_q <= flush;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (flush) begin
                        squash_q <= 1'b1;
                    end
                    if (dhit) begin
                        if (load_q) begin
                            data_q <= dmemload;
                        end else if (sc_q) begin
                            data_q <= WORD_W'(1);
                        end else begin
                            data_q <= addr_q;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    squash_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: pass-through vector table, directed LL/SC, flush and
// reset sequences, then random instruction streams against a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int K_ALU = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_LL  = 3;
    localparam int K_SC  = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ex_valid, ex_RegW, ex_halt, flush, dhit, snoop_inv;
    logic [1:0]  ex_Mem;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_alu_out, ex_store, dmemload, snoop_addr;
    logic        dmemREN, dmemWEN, mem_stall, wb_valid, wb_RegW, wb_halt;
    logic [31:0] dmemaddr, dmemstore, wb_data;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference link register: one valid bit and one address.
    logic        m_link_valid;
    logic [31:0] m_link_addr;

    logic [31:0] bases [4];

    typedef struct {
        logic        valid;
        logic [1:0]  mem;
        logic        regw;
        logic        halt;
        logic        flsh;
        logic [31:0] alu;
        logic        e_valid;
        logic        e_regw;
        logic        e_halt;
    } vec_t;

    vec_t tbl [7];

    mem_stage_ctrl #(.WORD_W(32), .LINK_EN(1'b1)) dut (
        .CLK(CLK), .nRST(nRST),
        .ex_valid(ex_valid), .ex_Mem(ex_Mem), .ex_opcode(ex_opcode),
        .ex_alu_out(ex_alu_out), .ex_store(ex_store), .ex_RegW(ex_RegW), .ex_halt(ex_halt),
        .flush(flush), .dhit(dhit), .dmemload(dmemload),
        .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_RegW(wb_RegW), .wb_halt(wb_halt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; ex_Mem = 0; ex_opcode = 0; ex_alu_out = 0; ex_store = 0;
        ex_RegW = 0; ex_halt = 0; flush = 0; dhit = 0; dmemload = 0;
        snoop_inv = 0; snoop_addr = 0;
    endtask

    task automatic model_snoop(input logic inv, input logic [31:0] a);
        if (inv && (a[31:2] == m_link_addr[31:2])) m_link_valid = 1'b0;
    endtask

    task automatic idle_cycle(input logic inv, input logic [31:0] a);
        clear_inputs();
        snoop_inv  = inv;
        snoop_addr = a;
        @(negedge CLK);
        check("idle_stall", mem_stall, 0);
        check("idle_valid", wb_valid, 0);
        model_snoop(inv, a);
        next_cycle();
        clear_inputs();
    endtask

    // One instruction from EXMEM entry to retirement. Called at posedge+1 with the DUT idle.
    // delay = ACCESS cycles up to and including the dhit cycle; *_at are per-instruction cycle
    // indices (0 = entry cycle), -1 for none.
    task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic regw, input logic hlt, input int delay,
                          input logic [31:0] ld, input int flush_at, input int snoop_at,
                          input logic [31:0] snoop_a);
        logic        is_mem, is_ld, sc_fail, squashed;
        logic [31:0] exp_data;
        is_mem  = (kind != K_ALU);
        is_ld   = (kind == K_LW) || (kind == K_LL);
        sc_fail = (kind == K_SC) && !(m_link_valid && (addr[31:2] == m_link_addr[31:2]));
        ex_valid   = 1'b1;
        ex_Mem     = !is_mem ? 2'b00 : (is_ld ? 2'b01 : 2'b10);
        case (kind)
            K_LW:    ex_opcode = 6'h23;
            K_SW:    ex_opcode = 6'h2B;
            K_LL:    ex_opcode = 6'h30;
            K_SC:    ex_opcode = 6'h38;
            default: ex_opcode = 6'h00;
        endcase
        ex_alu_out = addr;
        ex_store   = sdata;
        ex_RegW    = regw;
        ex_halt    = hlt;
        if (!is_mem || sc_fail) begin
            flush      = (flush_at == 0);
            snoop_inv  = (snoop_at == 0);
            snoop_addr = snoop_a;
            @(negedge CLK);
            check("pass_valid", wb_valid, 1);
            check("pass_data", wb_data, is_mem ? 32'd0 : addr);
            check("pass_regw", wb_RegW, regw && !flush);
            check("pass_halt", wb_halt, hlt);
            check("pass_stall", mem_stall, 0);
            check("pass_req", {dmemREN, dmemWEN}, 0);
            if (sc_fail) m_link_valid = 1'b0;
            model_snoop(snoop_inv, snoop_a);
            next_cycle();
        end else begin
            squashed = 1'b0;
            exp_data = (kind == K_SC) ? 32'd1 : (is_ld ? ld : addr);
            for (int c = 0; c <= delay + 1; c++) begin
                flush      = (c == flush_at);
                snoop_inv  = (c == snoop_at);
                snoop_addr = snoop_a;
                dhit       = (c == delay);
                dmemload   = (c == delay) ? ld : $urandom;
                if (flush) squashed = 1'b1;
                @(negedge CLK);
                if (c == 0) begin
                    check("enter_stall", mem_stall, 1);
                    check("enter_valid", wb_valid, 0);
                    check("enter_req", {dmemREN, dmemWEN}, 0);
                end else if (c <= delay) begin
                    check("acc_ren", dmemREN, is_ld);
                    check("acc_wen", dmemWEN, !is_ld);
                    check("acc_addr", dmemaddr, addr);
                    if (!is_ld) check("acc_store", dmemstore, sdata);
                    check("acc_stall", mem_stall, 1);
                    check("acc_valid", wb_valid, 0);
                end else begin
                    check("done_valid", wb_valid, 1);
                    check("done_data", wb_data, exp_data);
                    check("done_regw", wb_RegW, regw && !squashed);
                    check("done_halt", wb_halt, hlt && !squashed);
                    check("done_stall", mem_stall, 0);
                    check("done_req", {dmemREN, dmemWEN}, 0);
                end
                if (c == delay) begin
                    if (kind == K_LL) begin
                        m_link_valid = 1'b1;
                        m_link_addr  = addr;
                    end else if (!is_ld && ((kind == K_SC) || (addr[31:2] == m_link_addr[31:2]))) begin
                        m_link_valid = 1'b0;
                    end
                end
                model_snoop(snoop_inv, snoop_a);
                next_cycle();
            end
        end
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          kind, delay, f_at, s_at;
        logic [31:0] addr, s_a;

        bases[0] = 32'h100; bases[1] = 32'h104; bases[2] = 32'h200; bases[3] = 32'h204;
        tbl[0] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_0055, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0000_A5A5, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b1};

        clear_inputs();
        m_link_valid = 1'b0;
        m_link_addr  = '0;
        nRST = 1'b0;
        #12;
        check("rst_req", {dmemREN, dmemWEN}, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_wb", {wb_valid, wb_RegW, wb_halt}, 0);
        check("rst_data", wb_data, 0);
        check("rst_addr", dmemaddr, 0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        // Non-memory pass-through table.
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            ex_valid = tbl[i].valid; ex_Mem = tbl[i].mem; ex_RegW = tbl[i].regw;
            ex_halt = tbl[i].halt; flush = tbl[i].flsh; ex_alu_out = tbl[i].alu;
            @(negedge CLK);
            check("tbl_valid", wb_valid, tbl[i].e_valid);
            check("tbl_data", wb_data, tbl[i].alu);
            check("tbl_regw", wb_RegW, tbl[i].e_regw);
            check("tbl_halt", wb_halt, tbl[i].e_halt);
            check("tbl_stall", mem_stall, 0);
            check("tbl_req", {dmemREN, dmemWEN}, 0);
            next_cycle();
        end
        clear_inputs();

        // LW with three ACCESS cycles.
        run_op(K_LW, 32'h100, 0, 1, 0, 3, 32'hCAFE_F00D, -1, -1, 0);
        // LL / SC success / second SC fails.
        run_op(K_LL, 32'h200, 0, 1, 0, 1, 32'h11, -1, -1, 0);
        run_op(K_SC, 32'h200, 7, 1, 0, 1, 0, -1, -1, 0);
        run_op(K_SC, 32'h200, 7, 1, 0, 1, 0, -1, -1, 0);
        // Snoop to neighbouring word keeps the link.
        run_op(K_LL, 32'h200, 0, 1, 0, 2, 32'h22, -1, -1, 0);
        idle_cycle(1'b1, 32'h204);
        run_op(K_SC, 32'h200, 9, 1, 0, 1, 0, -1, -1, 0);
        // Snoop to the link word kills the following SC.
        run_op(K_LL, 32'h200, 0, 1, 0, 1, 32'h33, -1, -1, 0);
        idle_cycle(1'b1, 32'h204);
        idle_cycle(1'b1, 32'h200);
        run_op(K_SC, 32'h200, 9, 1, 0, 1, 0, -1, -1, 0);
        // Snoop hits the link while SC is in ACCESS: SC still returns 1.
        run_op(K_LL, 32'h200, 0, 1, 0, 1, 32'h44, -1, -1, 0);
        run_op(K_SC, 32'h200, 3, 1, 0, 2, 0, -1, 1, 32'h200);
        // Same-cycle LL dhit and matching snoop: link ends invalid.
        run_op(K_LL, 32'h300, 0, 1, 0, 2, 32'h55, -1, 2, 32'h300);
        run_op(K_SC, 32'h300, 1, 1, 0, 1, 0, -1, -1, 0);
        // Own SW to the link word clears it.
        run_op(K_LL, 32'h100, 0, 1, 0, 1, 32'h66, -1, -1, 0);
        run_op(K_SW, 32'h100, 5, 0, 0, 1, 0, -1, -1, 0);
        run_op(K_SC, 32'h100, 1, 1, 0, 1, 0, -1, -1, 0);
        // Flushed SW with a halt marker, then an ALU op proves return to IDLE.
        run_op(K_SW, 32'h180, 32'h1234, 1, 1, 3, 0, 2, -1, 0);
        run_op(K_ALU, 32'h55, 0, 1, 0, 1, 0, -1, -1, 0);

        // Asynchronous reset in the middle of an access.
        run_op(K_LL, 32'h200, 0, 1, 0, 1, 32'h77, -1, -1, 0);
        ex_valid = 1; ex_Mem = 2'b10; ex_opcode = 6'h2B; ex_alu_out = 32'h400; ex_store = 32'h99;
        @(negedge CLK);
        check("mid_enter_stall", mem_stall, 1);
        next_cycle();
        @(negedge CLK);
        check("mid_wen", dmemWEN, 1);
        #1 nRST = 1'b0;
        #1;
        check("mid_rst_wen", dmemWEN, 0);
        check("mid_rst_ren", dmemREN, 0);
        clear_inputs();
        #1;
        check("mid_rst_stall", mem_stall, 0);
        check("mid_rst_valid", wb_valid, 0);
        m_link_valid = 1'b0;
        m_link_addr  = '0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        run_op(K_SC, 32'h200, 5, 1, 0, 1, 0, -1, -1, 0);

        // Random instruction stream.
        for (int i = 0; i < 200; i++) begin
            kind  = $urandom_range(4, 0);
            addr  = bases[$urandom_range(3, 0)] | 32'($urandom_range(3, 0));
            if (kind == K_SC && $urandom_range(1, 0) == 1) addr = m_link_addr;
            if (kind == K_ALU) addr = $urandom;
            delay = $urandom_range(4, 1);
            f_at  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(delay + 1, 0)) : -1;
            s_at  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(delay + 1, 0)) : -1;
            s_a   = bases[$urandom_range(3, 0)];
            run_op(kind, addr, $urandom, 1'($urandom), 1'($urandom), delay, $urandom,
                   f_at, s_at, s_a);
            if ($urandom_range(3, 0) == 0) idle_cycle(1'($urandom), bases[$urandom_range(3, 0)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
